// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache memory-port arbiter.
// The state enum is used by the arbiter and by anything that decodes its state.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Physical-memory port bundle: the arbiter drives it as master and memory answers as slave.
// One line-wide transaction is in flight at a time; resp is a single-cycle completion pulse.
interface cache_arbiter_if #(
    parameter int LINE_W = 256
);
    logic              read;
    logic              write;
    logic [31:0]       address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_arbiter_sat_counter.sv
// Debug event counter that clears synchronously and sticks at all-ones.
// Sticking instead of wrapping keeps a long-running count from reading as small.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache miss paths.
// D wins ties from IDLE; on completion the grant passes to the other waiting cache.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_read,
    input  logic [31:0]          i_address,
    output logic [LINE_W-1:0]    i_rdata,
    output logic                 i_resp,

    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_address,
    input  logic [LINE_W-1:0]    d_wdata,
    output logic [LINE_W-1:0]    d_rdata,
    output logic                 d_resp,

    cache_arbiter_if.master      pmem,

    output logic [CNT_W-1:0]     i_grant_cnt,
    output logic [CNT_W-1:0]     d_grant_cnt,
    output logic [CNT_W-1:0]     conflict_cnt
);

    typedef struct packed {
        arb_state_t        next;
        logic              read;
        logic              write;
        logic [31:0]       address;
        logic [LINE_W-1:0] wdata;
        logic              i_resp;
        logic              d_resp;
    } arb_ctl_t;

    arb_state_t state;
    arb_ctl_t   ctl;
    logic       i_req;
    logic       d_req;
    logic       i_enter;
    logic       d_enter;
    logic       conflict;

    function automatic arb_ctl_t ctl_defaults(input arb_state_t cur);
        arb_ctl_t c;
        c      = '0;
        c.next = cur;
        return c;
    endfunction

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= ctl.next;
        end
    end

    // The completing cache's request is still high in its resp cycle, so only the other side is tested.
    always_comb begin
        ctl = ctl_defaults(state);
        unique case (state)
            IDLE: begin
                if (d_req) begin
                    ctl.next = SERVE_D;
                end else if (i_req) begin
                    ctl.next = SERVE_I;
                end
            end
            SERVE_I: begin
                ctl.read    = 1'b1;
                ctl.address = i_address;
                ctl.i_resp  = pmem.resp;
                if (pmem.resp) begin
                    ctl.next = d_req ? SERVE_D : IDLE;
                end
            end
            SERVE_D: begin
                ctl.read    = d_read;
                ctl.write   = d_write;
                ctl.address = d_address;
                ctl.wdata   = d_wdata;
                ctl.d_resp  = pmem.resp;
                if (pmem.resp) begin
                    ctl.next = i_req ? SERVE_I : IDLE;
                end
            end
            default: begin
                ctl.next = IDLE;
            end
        endcase
    end

    assign pmem.read    = ctl.read;
    assign pmem.write   = ctl.write;
    assign pmem.address = ctl.address;
    assign pmem.wdata   = ctl.wdata;
    assign i_resp       = ctl.i_resp;
    assign d_resp       = ctl.d_resp;
    assign i_rdata      = pmem.rdata;
    assign d_rdata      = pmem.rdata;

    assign i_enter  = (ctl.next == SERVE_I) && (state != SERVE_I);
    assign d_enter  = (ctl.next == SERVE_D) && (state != SERVE_D);
    assign conflict = ((state == SERVE_I) && d_req) || ((state == SERVE_D) && i_req);

    sat_counter #(.CNT_W(CNT_W)) u_i_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_enter),
        .count (i_grant_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_enter),
        .count (d_grant_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict),
        .count (conflict_cnt)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised and directed bench for cache_arbiter with an ownership model, memory responder and
// per-cache response scoreboards; small counters so saturation is reached.
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int CNT_W  = 5;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_read = 1'b0;
    logic [31:0]       i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [31:0]       d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;
    logic [CNT_W-1:0]  conflict_cnt;

    cache_arbiter_if #(.LINE_W(LINE_W)) pmem ();

    cache_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem         (pmem),
        .i_grant_cnt  (i_grant_cnt),
        .d_grant_cnt  (d_grant_cnt),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] mem_data(input logic [31:0] a);
        if (a == 32'h60) return {32{8'hA5}};
        return {8{a ^ 32'h5A3C_9617}} ^ {{(LINE_W-32){1'b0}}, a};
    endfunction

    // Physical memory: arbitrary latency between lat_lo and lat_hi, reset by the same rst.
    int   lat_lo = 0;
    int   lat_hi = 5;
    logic spurious = 1'b0;
    initial begin
        int busy;
        int remain;
        busy = 0;
        remain = 0;
        pmem.resp = 1'b0;
        pmem.rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem.resp = 1'b0;
            pmem.rdata = {8{$urandom}};
            if (rst) begin
                busy = 0;
            end else if (spurious) begin
                pmem.resp = 1'b1;
                spurious = 1'b0;
            end else begin
                if (busy == 0 && (pmem.read || pmem.write)) begin
                    busy = 1;
                    remain = $urandom_range(lat_hi, lat_lo);
                end
                if (busy != 0) begin
                    if (remain == 0) begin
                        pmem.resp = 1'b1;
                        pmem.rdata = mem_data(pmem.address);
                        busy = 0;
                    end else begin
                        remain--;
                    end
                end
            end
        end
    end

    // Reference model: who owns the port (0 none, 1 I, 2 D), expected counters, grant log.
    int  owner = 0;
    int  ei = 0, ed = 0, ec = 0;
    int  d_serve = 0;
    byte glog[$];
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic er, ew, eir, edr;
                logic [31:0] ea;
                logic [LINE_W-1:0] ewd;
                logic ireq, dreq;
                er = 0; ew = 0; eir = 0; edr = 0; ea = '0; ewd = '0;
                ireq = i_read;
                dreq = d_read | d_write;
                if (owner == 1) begin
                    er = 1; ea = i_address; eir = pmem.resp;
                end else if (owner == 2) begin
                    er = d_read; ew = d_write; ea = d_address; ewd = d_wdata; edr = pmem.resp;
                end
                chk("pmem_read", pmem.read, er);
                chk("pmem_write", pmem.write, ew);
                chk("pmem_address", pmem.address, ea);
                if (owner != 1) chk("pmem_wdata", pmem.wdata, ewd);
                chk("i_resp", i_resp, eir);
                chk("d_resp", d_resp, edr);
                chk("i_rdata_pass", i_rdata, pmem.rdata);
                chk("d_rdata_pass", d_rdata, pmem.rdata);
                chk("i_grant_cnt", i_grant_cnt, ei);
                chk("d_grant_cnt", d_grant_cnt, ed);
                chk("conflict_cnt", conflict_cnt, ec);
                assert (!(d_read && d_write)) else $error("FAIL illegal d_read and d_write together");
                if (rst) begin
                    owner = 0; ei = 0; ed = 0; ec = 0; d_serve = 0;
                end else begin
                    if ((owner == 1 && dreq) || (owner == 2 && ireq)) ec = (ec < CMAX) ? ec + 1 : ec;
                    if (owner == 2) d_serve++;
                    if (owner == 0) begin
                        if (dreq) owner = 2;
                        else if (ireq) owner = 1;
                        if (owner != 0) glog.push_back(owner == 2 ? "D" : "I");
                        if (owner == 2) ed = (ed < CMAX) ? ed + 1 : ed;
                        if (owner == 1) ei = (ei < CMAX) ? ei + 1 : ei;
                    end else if (pmem.resp) begin
                        if (owner == 1 && dreq) begin
                            owner = 2; ed = (ed < CMAX) ? ed + 1 : ed; glog.push_back("D");
                        end else if (owner == 2 && ireq) begin
                            owner = 1; ei = (ei < CMAX) ? ei + 1 : ei; glog.push_back("I");
                        end else begin
                            owner = 0;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard: each issued request pushes its address; a response pops and checks the data.
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    int i_pulses = 0;
    int d_pulses = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (i_resp) begin
                i_pulses++;
                tests++;
                if (iq.size() == 0) begin
                    fails++;
                    $display("FAIL i_resp_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    tests--;
                    chk("i_rdata_resp", i_rdata, mem_data(iq.pop_front()));
                end
            end
            if (d_resp) begin
                d_pulses++;
                tests++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL d_resp_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    tests--;
                    chk("d_rdata_resp", d_rdata, mem_data(dq.pop_front()));
                end
            end
        end
    end

    task automatic wait_resp(input bit is_d);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (is_d ? d_resp : i_resp) break;
        end
        tests++;
        if (k >= 300) begin
            fails++;
            $display("FAIL %s_timeout: got no resp expected resp within 300 cycles", is_d ? "d" : "i");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_i(input logic [31:0] a);
        i_read = 1'b1;
        i_address = a;
        iq.push_back(a);
        wait_resp(1'b0);
        i_read = 1'b0;
    endtask

    task automatic do_d(input logic [31:0] a, input bit wr, input logic [LINE_W-1:0] wd);
        d_read = !wr;
        d_write = wr;
        d_address = a;
        d_wdata = wd;
        dq.push_back(a);
        wait_resp(1'b1);
        d_read = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iq.delete();
        dq.delete();
        glog.delete();
    endtask

    task automatic chk_log(input string nm, input string exp);
        string got;
        got = "";
        foreach (glog[k]) got = {got, string'(glog[k])};
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got order '%s' expected '%s'", nm, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ip, dp;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_i_cnt", i_grant_cnt, 0);
        chk("rst_conflict_cnt", conflict_cnt, 0);
        chk("rst_pmem_read", pmem.read, 0);

        // Lone I-miss with a fixed 5-cycle memory.
        lat_lo = 4; lat_hi = 4;
        ip = i_pulses; dp = d_pulses;
        do_i(32'h0000_0060);
        chk("lone_i_pulses", i_pulses - ip, 1);
        chk("lone_d_pulses", d_pulses - dp, 0);
        chk("lone_i_cnt", i_grant_cnt, 1);

        // Simultaneous requests: D first, I straight after; conflicts span D's service.
        do_reset();
        lat_lo = 2; lat_hi = 6;
        fork
            do_d(32'h200, 1'b0, '0);
            do_i(32'h100);
        join
        chk_log("simul_order", "DI");
        chk("simul_conflict", conflict_cnt, d_serve);

        // Write-back.
        do_reset();
        dp = d_pulses;
        do_d(32'h80, 1'b1, {8{32'h1234_5678}});
        chk("wb_d_pulses", d_pulses - dp, 1);
        chk("wb_d_cnt", d_grant_cnt, 1);

        // Alternation under continuous re-requests.
        do_reset();
        lat_lo = 0; lat_hi = 3;
        fork
            begin
                do_d(32'h400, 1'b0, '0);
                do_d(32'h420, 1'b1, {8{32'hCAFE_0001}});
                do_d(32'h440, 1'b0, '0);
            end
            begin
                do_i(32'h500);
                do_i(32'h520);
                do_i(32'h540);
            end
        join
        chk_log("alt_order", "DIDIDI");
        chk("alt_i_cnt", i_grant_cnt, 3);
        chk("alt_d_cnt", d_grant_cnt, 3);

        // Reset two cycles into a D write-back abandons it.
        do_reset();
        lat_lo = 10; lat_hi = 10;
        d_write = 1'b1; d_address = 32'h600; d_wdata = {8{32'hDEAD_BEEF}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; d_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dq.delete();
        chk("midrst_pmem_write", pmem.write, 0);
        chk("midrst_d_cnt", d_grant_cnt, 0);
        chk("midrst_conflict", conflict_cnt, 0);
        lat_lo = 1; lat_hi = 3;
        do_d(32'h640, 1'b0, '0);
        chk("midrst_after_d_cnt", d_grant_cnt, 1);

        // Spurious memory response while idle.
        do_reset();
        spurious = 1'b1;
        @(negedge clk);
        chk("spur_resps", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_log("spur_no_grant", "");
        chk("spur_pmem_read", pmem.read, 0);

        // Randomised traffic long enough to saturate the grant counters.
        @(posedge clk);
        #1;
        do_reset();
        lat_lo = 0; lat_hi = 5;
        fork
            for (int n = 0; n < 40; n++) begin
                logic [31:0] r;
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                r = $urandom;
                do_i({r[31:5], 5'b0});
            end
            for (int m = 0; m < 40; m++) begin
                logic [31:0] r;
                logic [31:0] w;
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                r = $urandom;
                w = $urandom;
                do_d({r[31:5], 5'b0}, r[0], {8{w}});
            end
        join
        chk("rand_i_sat", i_grant_cnt, CMAX);
        chk("rand_d_sat", d_grant_cnt, CMAX);
        chk("rand_iq_drained", iq.size(), 0);
        chk("rand_dq_drained", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the pipelined RV32I core. It grants one requester at a time through a registered three-state FSM, routes address, write data and response to the granted cache, and holds the other cache waiting. The caches keep their `*_resp` low while waiting, so the core's stall logic freezes the pipeline. Saturating performance counters record grants and contention cycles for debug.

## Interface
Parameters:
- `LINE_W`, default 256: cache-line width in bits.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `i_read`  in  1  I-cache line-fill request; held high until `i_resp`.
- `i_address`  in  32  I-cache line address; stable while `i_read` is high.
- `i_rdata`  out  LINE_W  fill data to the I-cache.
- `i_resp`  out  1  I-cache transaction complete; one-cycle pulse.
- `d_read`  in  1  D-cache line-fill request.
- `d_write`  in  1  D-cache write-back request.
- `d_address`  in  32  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache write-back data.
- `d_rdata`  out  LINE_W  fill data to the D-cache.
- `d_resp`  out  1  D-cache transaction complete; one-cycle pulse.
- `pmem_read`  out  1  read request to physical memory.
- `pmem_write`  out  1  write request to physical memory.
- `pmem_address`  out  32  physical-memory address.
- `pmem_wdata`  out  LINE_W  physical-memory write data.
- `pmem_rdata`  in  LINE_W  physical-memory read data.
- `pmem_resp`  in  1  physical memory done; one-cycle pulse.
- `i_grant_cnt`  out  CNT_W  number of I-cache grants.
- `d_grant_cnt`  out  CNT_W  number of D-cache grants.
- `conflict_cnt`  out  CNT_W  cycles in which a requester waits while the other holds the grant.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
  - Reset state: `IDLE`.
- Pending flags: `i_req = i_read`; `d_req = d_read | d_write`.
- Transitions from `IDLE`:
  - `d_req` → `SERVE_D`. The D-cache wins a tie because the data miss belongs to the older instruction.
  - otherwise `i_req` → `SERVE_I`.
  - otherwise stay in `IDLE`.
- Transitions from `SERVE_I` on `pmem_resp`: go to `SERVE_D` if `d_req`, else `IDLE`.
- Transitions from `SERVE_D` on `pmem_resp`: go to `SERVE_I` if `i_req`, else `IDLE`.
- Hand-off rules:
  - Alternating on completion means neither requester starves.
  - The completing requester is never re-granted straight away; its request is still high in the response cycle and must be ignored.
- Outputs in `SERVE_I` (combinational from state):
  - `pmem_read = 1`, `pmem_write = 0`, `pmem_address = i_address`.
  - `i_resp = pmem_resp`.
- Outputs in `SERVE_D`:
  - `pmem_read = d_read`, `pmem_write = d_write`, `pmem_address = d_address`, `pmem_wdata = d_wdata`.
  - `d_resp = pmem_resp`.
- Outputs in `IDLE`:
  - `pmem_read = 0`, `pmem_write = 0`, `pmem_address = 0`, `pmem_wdata = 0`.
  - Both `*_resp` = 0.
- `i_rdata` and `d_rdata` are both driven by `pmem_rdata` at all times. Only the `*_resp` signals are gated by the grant.
- `pmem_resp` arriving in `IDLE` is ignored and raises no `*_resp`.
- `d_read` and `d_write` high together is illegal. It is not corrected, only flagged by a bench assertion.
- Counter updates:
  - `i_grant_cnt` increments on every entry into `SERVE_I`; `d_grant_cnt` on every entry into `SERVE_D`.
  - `conflict_cnt` increments in a cycle when the state is `SERVE_I` with `d_req` high, or `SERVE_D` with `i_req` high.
  - All counters saturate at all-ones.

## Timing
- Reset:
  - `rst` high at an edge → state `IDLE`, all counters 0.
  - From that edge, `pmem_read = pmem_write = i_resp = d_resp = 0`.
  - Reset during a grant abandons the in-flight transaction. Physical memory is reset by the same `rst`.
- Grant latency:
  - Request first high in `IDLE` at edge t → FSM enters `SERVE_x` at edge t+1.
  - `pmem_read`/`pmem_write` are visible from t+1 until the `pmem_resp` cycle inclusive.
- Response:
  - `*_resp` is combinational and arrives in the same cycle as `pmem_resp`.
  - At the following edge the FSM leaves the serve state.
- Back-to-back hand-off: the second requester's `pmem_*` request is driven the cycle immediately after the first one's `pmem_resp`, with no idle cycle.
- Memory latency is arbitrary. The FSM holds the serve state for any number of cycles until `pmem_resp`.

## Structure
- Shared package `arbiter_types` holds `typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t`.
- Sub-module `sat_counter #(CNT_W)`, instantiated three times.
  - Ports: `clk`, `rst`, `inc`, `count`.
  - Synchronous clear; saturating increment.
- The arbiter itself is one `always_ff` for state plus one `always_comb` with a defaults function covering next-state and outputs.

## Test plan
- Lone I-miss: `i_read = 1`, `i_address = 0x0000_0060`; memory responds after 5 cycles with `rdata = 0xA5…A5` → `pmem_address = 0x60`, `i_resp` pulses once carrying `0xA5…A5`, `i_grant_cnt = 1`, `d_resp` stays 0.
- Simultaneous requests: `i_read` and `d_read` rise in the same cycle (I address 0x100, D address 0x200) → the D transaction is served first, then I is granted the cycle after D's `pmem_resp`; `conflict_cnt` equals D's service cycles.
- Write-back: `d_write = 1`, `d_address = 0x80`, `d_wdata = 0x1234…` → `pmem_write = 1` with matching `pmem_wdata`, `pmem_read = 0`, `d_resp` pulses once.
- Alternation: both caches keep re-requesting for 6 transactions → grant order is D, I, D, I, D, I; `i_grant_cnt = d_grant_cnt = 3`.
- Reset mid-grant: `rst` asserted 2 cycles into `SERVE_D` → next cycle `pmem_write = 0`, state `IDLE`, all counters 0; a later request is serviced normally.
- Spurious response: `pmem_resp` pulsed in `IDLE` → no `*_resp`, state stays `IDLE`.
